// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         CNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// rx handshake: a byte transfers on the rising edge where rx_valid && rx_ready are
// both high; rx_data must be stable while rx_valid is high, at most one byte per cycle.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  // master: stream source and memory; slave: the loader
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_waddr, imem_wdata
  );

endinterface

// File: rtl/loader_word_packer.sv
// Packs accepted data bytes little-endian into 32-bit words and pulses word_we
// for one cycle after the fourth byte; word holds until the next completed word.
module loader_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        last_lane,
  output logic        word_we,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] sr;

  assign last_lane = (lane == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane    <= 2'd0;
      sr      <= 24'd0;
      word_we <= 1'b0;
      word    <= 32'd0;
    end else begin
      word_we <= 1'b0;
      if (clr) begin
        lane <= 2'd0;
      end else if (byte_en) begin
        lane <= lane + 2'd1;
        // Newest byte enters at the top so byte 0 ends up in word[7:0]
        if (last_lane) begin
          word    <= {byte_in, sr};
          word_we <= 1'b1;
        end else begin
          sr <= {byte_in, sr[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Frame parser, checksum and sequential instruction-memory writer; holds the
// core in reset until a checksum-valid image has been fully written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus,
  output logic          core_rst,
  output logic          done,
  output logic          err,
  output state_t        dbg_state
);

  // Largest legal word count is a completely full memory
  localparam logic [CNT_W:0]   MAX_WORDS = {{CNT_W{1'b0}}, 1'b1} << ADDR_W;
  localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic              accept;
  logic              data_en;
  logic              restart;
  logic [7:0]        cnt_lo;
  logic [CNT_W-1:0]  cnt_full;
  logic [CNT_W-1:0]  n_words;
  logic [CNT_W-1:0]  widx;
  logic [7:0]        sum;
  logic [ADDR_W-1:0] waddr;
  logic              last_lane;
  logic              word_we;
  logic [31:0]       word;

  assign bus.rx_ready = (state != ST_DONE);
  assign accept       = bus.rx_valid && bus.rx_ready;
  assign cnt_full     = {bus.rx_data, cnt_lo};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    data_en   = 1'b0;
    restart   = 1'b0;
    if (accept) begin
      case (state)
        ST_IDLE, ST_ERR: begin
          if (bus.rx_data == SYNC_BYTE) begin
            state_nxt = ST_CNT_LO;
            restart   = 1'b1;
          end
        end
        ST_CNT_LO: state_nxt = ST_CNT_HI;
        ST_CNT_HI: begin
          if ({1'b0, cnt_full} > MAX_WORDS) state_nxt = ST_ERR;
          else if (cnt_full == '0)          state_nxt = ST_CSUM;
          else                              state_nxt = ST_DATA;
        end
        ST_DATA: begin
          data_en = 1'b1;
          if (last_lane && ((widx + ONE) == n_words)) state_nxt = ST_CSUM;
        end
        ST_CSUM: state_nxt = (bus.rx_data == sum) ? ST_DONE : ST_ERR;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_lo  <= 8'd0;
      n_words <= '0;
      widx    <= '0;
      sum     <= 8'd0;
      waddr   <= '0;
    end else begin
      if (restart) begin
        sum  <= 8'd0;
        widx <= '0;
      end
      if (accept && state == ST_CNT_LO) cnt_lo  <= bus.rx_data;
      if (accept && state == ST_CNT_HI) n_words <= cnt_full;
      if (data_en) begin
        sum <= sum + bus.rx_data;
        // Address is registered alongside the packer's word so both appear with imem_we
        if (last_lane) begin
          waddr <= widx[ADDR_W-1:0];
          widx  <= widx + ONE;
        end
      end
    end
  end

  loader_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (restart),
    .byte_en   (data_en),
    .byte_in   (bus.rx_data),
    .last_lane (last_lane),
    .word_we   (word_we),
    .word      (word)
  );

  assign bus.imem_we    = word_we;
  assign bus.imem_waddr = waddr;
  assign bus.imem_wdata = word;
  assign done           = (state == ST_DONE);
  assign err            = (state == ST_ERR);
  assign core_rst       = (state != ST_DONE);
  assign dbg_state      = state;

endmodule

// File: tb/tb_imem_loader.sv
// Scenario bench for imem_loader: framed byte streams in, memory writes scoreboarded.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 8;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   core_rst, done, err;
  state_t dbg_state;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .core_rst  (core_rst),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] got_q[$];
  int                 rd_idx = 0;

  logic [7:0] nominal [12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00,
                               8'h00, 8'hB3, 8'h01, 8'h21, 8'h00, 8'hE8};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Every cycle with imem_we high is one observed write
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) got_q.push_back({bus.imem_waddr, bus.imem_wdata});
  end

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int wait_cyc;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    wait_cyc = 0;
    while (bus.rx_ready !== 1'b1 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (bus.rx_ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL rx_ready_timeout: byte %h, rx_ready=%b required 1", b, bus.rx_ready);
    end else begin
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap, input logic [7:0] last_byte);
    for (int i = 0; i < 11; i++) send_byte(nominal[i], max_gap);
    send_byte(last_byte, max_gap);
  endtask

  task automatic push_nominal();
    exp_q.push_back({8'd0, 32'h0000_0013});
    exp_q.push_back({8'd1, 32'h0021_01B3});
  endtask

  // ---------------- scoreboard drain ----------------
  task automatic check_writes(input string name);
    logic [ADDR_W+31:0] exp_w;
    logic [ADDR_W+31:0] got_w;
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      tests_run++;
      if (rd_idx >= got_q.size()) begin
        tests_failed++;
        $display("FAIL %s write: got no write, required addr=%0d data=%h",
                 name, exp_w[ADDR_W+31:32], exp_w[31:0]);
      end else begin
        got_w = got_q[rd_idx];
        rd_idx++;
        if (got_w !== exp_w) begin
          tests_failed++;
          $display("FAIL %s write: got addr=%0d data=%h, required addr=%0d data=%h",
                   name, got_w[ADDR_W+31:32], got_w[31:0], exp_w[ADDR_W+31:32], exp_w[31:0]);
        end
      end
    end
    tests_run++;
    if (got_q.size() != rd_idx) begin
      tests_failed++;
      $display("FAIL %s extra_writes: got %0d unexpected writes, required 0",
               name, got_q.size() - rd_idx);
      rd_idx = got_q.size();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
    end
    tests_run++;
    if ({bus.rx_ready, core_rst, done, err, bus.imem_we} !== 5'b11000) begin
      tests_failed++;
      $display("FAIL reset_flags: got rdy/crst/done/err/we=%b, required 11000",
               {bus.rx_ready, core_rst, done, err, bus.imem_we});
    end
    tests_run++;
    if ({bus.imem_waddr, bus.imem_wdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: got addr=%h data=%h, required 0 0", bus.imem_waddr, bus.imem_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_nominal();
    do_reset();
    push_nominal();
    for (int i = 0; i < 11; i++) send_byte(nominal[i], 0);
    tests_run++;
    if ({done, core_rst} !== 2'b01) begin
      tests_failed++;
      $display("FAIL nominal_before_csum: got done/core_rst=%b, required 01", {done, core_rst});
    end
    send_byte(8'hE8, 0);
    tests_run++;
    if ({done, core_rst, err} !== 3'b100) begin
      tests_failed++;
      $display("FAIL nominal_done: got done/core_rst/err=%b, required 100", {done, core_rst, err});
    end
    check_writes("nominal");
  endtask

  task automatic test_bad_csum();
    do_reset();
    push_nominal();
    send_frame(0, 8'hE9);
    tests_run++;
    if ({err, done, core_rst, bus.rx_ready} !== 4'b1011) begin
      tests_failed++;
      $display("FAIL bad_csum_err: got err/done/core_rst/rdy=%b, required 1011",
               {err, done, core_rst, bus.rx_ready});
    end
    check_writes("bad_csum");
    push_nominal();
    send_byte(8'hA5, 0);
    tests_run++;
    if ({err, dbg_state} !== {1'b0, ST_CNT_LO}) begin
      tests_failed++;
      $display("FAIL resend_sync: got err=%b state=%0d, required err=0 state=%0d",
               err, dbg_state, ST_CNT_LO);
    end
    for (int i = 1; i < 12; i++) send_byte(nominal[i], 0);
    tests_run++;
    if ({done, core_rst, err} !== 3'b100) begin
      tests_failed++;
      $display("FAIL resend_done: got done/core_rst/err=%b, required 100", {done, core_rst, err});
    end
    check_writes("resend");
  endtask

  task automatic test_noise_empty();
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    tests_run++;
    if (dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL noise_dropped: got state %0d, required %0d", dbg_state, ST_IDLE);
    end
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    tests_run++;
    if (dbg_state !== ST_CSUM) begin
      tests_failed++;
      $display("FAIL empty_to_csum: got state %0d, required %0d", dbg_state, ST_CSUM);
    end
    send_byte(8'h00, 0);
    tests_run++;
    if ({done, core_rst, err} !== 3'b100) begin
      tests_failed++;
      $display("FAIL empty_done: got done/core_rst/err=%b, required 100", {done, core_rst, err});
    end
    check_writes("empty");
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL oversize_early: got err=%b before CNT_HI, required 0", err);
    end
    send_byte(8'h01, 0);
    tests_run++;
    if ({err, done, core_rst, dbg_state} !== {3'b101, ST_ERR}) begin
      tests_failed++;
      $display("FAIL oversize_err: got err/done/core_rst=%b state=%0d, required 101 state=%0d",
               {err, done, core_rst}, dbg_state, ST_ERR);
    end
    check_writes("oversize");
  endtask

  task automatic test_stalls();
    do_reset();
    push_nominal();
    send_frame(4, 8'hE8);
    tests_run++;
    if ({done, core_rst} !== 2'b10) begin
      tests_failed++;
      $display("FAIL stalls_done: got done/core_rst=%b, required 10", {done, core_rst});
    end
    check_writes("stalls");
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(nominal[i], 0);
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({bus.rx_ready, core_rst, done, err, bus.imem_we, bus.imem_waddr, bus.imem_wdata, dbg_state}
        !== {5'b11000, {ADDR_W{1'b0}}, 32'd0, ST_IDLE}) begin
      tests_failed++;
      $display("FAIL midreset_values: got rdy/crst/done/err/we=%b addr=%h data=%h state=%0d, required 11000 0 0 %0d",
               {bus.rx_ready, core_rst, done, err, bus.imem_we}, bus.imem_waddr, bus.imem_wdata,
               dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst = 1'b1;
    push_nominal();
    send_frame(1, 8'hE8);
    tests_run++;
    if ({done, core_rst, err} !== 3'b100) begin
      tests_failed++;
      $display("FAIL midreset_reload: got done/core_rst/err=%b, required 100", {done, core_rst, err});
    end
    check_writes("midreset");
  endtask

  task automatic test_done_lockout();
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.rx_data = 8'(i * 37);
      tests_run++;
      if ({bus.rx_ready, done, core_rst} !== 3'b010) begin
        tests_failed++;
        $display("FAIL lockout_cycle%0d: got rdy/done/core_rst=%b, required 010",
                 i, {bus.rx_ready, done, core_rst});
      end
    end
    bus.rx_valid = 1'b0;
    check_writes("lockout");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_nominal();
    test_bad_csum();
    test_noise_empty();
    test_oversize();
    test_stalls();
    test_reset_mid_frame();
    test_done_lockout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
